// File: rtl/breath_led_multi.sv
// Multi-channel breathing-LED driver: one shared prescaler/PWM/phase timebase feeding
// CH_NUM phase-shifted channels. Define BREATH_GAMMA_EN for a square-law duty curve.
module breath_led_multi #(
  parameter int CH_NUM      = 4,
  parameter int CLK_DIV     = 50,
  parameter int PWM_BITS    = 10,
  parameter int HOLD_FRAMES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  restart,
  input  logic [2*CH_NUM-1:0]   mode,
  output logic [CH_NUM-1:0]     led_o,
  output logic                  cycle_o
);

  localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FR_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam int POS_W = PWM_BITS + 1;

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(HOLD_FRAMES - 1);

  if (CH_NUM < 1 || CH_NUM > 16 || CLK_DIV < 1 || HOLD_FRAMES < 1 || PWM_BITS < 1) begin : g_bad_param
    $error("breath_led_multi: parameter out of range");
  end

  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FR_W-1:0]     frame_cnt;
  logic [POS_W-1:0]    pos;

  logic tick;
  logic frame_end;
  logic step;
  logic [CH_NUM-1:0] led_next;

  assign tick      = (prescaler == PS_LAST);
  assign frame_end = tick && (&pwm_cnt);
  assign step      = frame_end && (frame_cnt == FR_LAST);

  // Shared timebase; restart clears it without pulsing cycle_o, even on a coincident wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      frame_cnt <= '0;
      pos       <= '0;
      cycle_o   <= 1'b0;
    end else if (!en || restart) begin
      prescaler <= '0;
      pwm_cnt   <= '0;
      frame_cnt <= '0;
      pos       <= '0;
      cycle_o   <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (frame_end) begin
        frame_cnt <= (frame_cnt == FR_LAST) ? '0 : frame_cnt + 1'b1;
      end
      if (step) begin
        pos <= pos + 1'b1;
      end
      cycle_o <= step && (&pos);
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    localparam logic [POS_W-1:0] OFF = POS_W'((i * (2 ** POS_W)) / CH_NUM);

    logic [POS_W-1:0]    phase;
    logic [PWM_BITS-1:0] tri_v;
    logic [PWM_BITS-1:0] duty;
    logic                drive;

    assign phase = pos + OFF;
    // Second half of the phase period mirrors the first to form the triangle.
    assign tri_v = phase[PWM_BITS] ? ~phase[PWM_BITS-1:0] : phase[PWM_BITS-1:0];

`ifdef BREATH_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    assign sq   = {{PWM_BITS{1'b0}}, tri_v} * {{PWM_BITS{1'b0}}, tri_v};
    assign duty = sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = tri_v;
`endif

    always_comb begin
      drive = 1'b0;
      case (mode[2*i +: 2])
        2'b00:   drive = 1'b0;
        2'b01:   drive = 1'b1;
        2'b10:   drive = (duty > pwm_cnt);
        default: drive = phase[PWM_BITS];
      endcase
    end

    assign led_next[i] = drive;
  end

  // Output register sees the pre-clear timebase on a restart cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_o <= '0;
    end else if (!en) begin
      led_o <= '0;
    end else begin
      led_o <= led_next;
    end
  end

endmodule

// File: tb/tb_breath_led_multi.sv
// Scoreboard bench for breath_led_multi with CH_NUM=2, CLK_DIV=2, PWM_BITS=3, HOLD_FRAMES=1:
// a frame is 16 clk and the full phase period is 256 clk.
module tb_breath_led_multi;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       restart;
  logic [3:0] mode;
  logic [1:0] led_o;
  logic       cycle_o;

  breath_led_multi #(
    .CH_NUM(2), .CLK_DIV(2), .PWM_BITS(3), .HOLD_FRAMES(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .mode(mode), .led_o(led_o), .cycle_o(cycle_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [1:0] led;
    logic       cyc;
    int         win;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_model  = 0;
  int   n_pre    = 0;
  bit   win_en   = 0;
  int   hi0[16];
  int   hi1[16];
  int   cyc_acc  = 0;

  task automatic checkOutput(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // Clock count since the last clear fully determines prescaler, pwm_cnt and pos.
  function automatic logic [1:0] model_led(input logic [3:0] m, input int n);
    int pwm, ph_pos, p, t;
    logic [1:0] r;
    pwm    = (n / 2) % 8;
    ph_pos = (n / 16) % 16;
    r      = 2'b00;
    for (int ch = 0; ch < 2; ch++) begin
      p = (ph_pos + ch * 8) % 16;
      t = (p >= 8) ? 7 - (p % 8) : p;
      case (m[2*ch +: 2])
        2'b00:   r[ch] = 1'b0;
        2'b01:   r[ch] = 1'b1;
        2'b10:   r[ch] = (t > pwm);
        default: r[ch] = (p >= 8);
      endcase
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic en_v, input logic restart_v,
                               input logic [3:0] mode_v, input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    en      = en_v;
    restart = restart_v;
    mode    = mode_v;
    n_pre   = n_model;
    e.tag   = tag;
    e.win   = win_en ? (n_model / 16) % 16 : -1;
    if (!en_v) begin
      e.led   = 2'b00;
      e.cyc   = 1'b0;
      n_model = 0;
    end else begin
      e.led   = model_led(mode_v, n_model);
      e.cyc   = !restart_v && (n_model == 255);
      n_model = restart_v ? 0 : (n_model + 1) % 256;
    end
    sb_q.push_back(e);
  endtask

  task automatic checkTimebase(input string tag);
    checkOutput({tag, "/prescaler"}, int'(dut.prescaler), n_pre % 2);
    checkOutput({tag, "/pwm_cnt"}, int'(dut.pwm_cnt), (n_pre / 2) % 8);
    checkOutput({tag, "/pos"}, int'(dut.pos), (n_pre / 16) % 16);
  endtask

  task automatic clearWindows();
    foreach (hi0[k]) begin
      hi0[k] = 0;
      hi1[k] = 0;
    end
    cyc_acc = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checkOutput({e.tag, "/led"}, int'(led_o), int'(e.led));
      checkOutput({e.tag, "/cycle"}, int'(cycle_o), int'(e.cyc));
      if (e.win >= 0) begin
        hi0[e.win] += int'(led_o[0]);
        hi1[e.win] += int'(led_o[1]);
        cyc_acc    += int'(cycle_o);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; restart = 1'b0; mode = 4'b0000;
    clearWindows();
    #12;
    checkOutput("reset_led", int'(led_o), 0);
    checkOutput("reset_cycle", int'(cycle_o), 0);
    checkOutput("reset_pwm", int'(dut.pwm_cnt), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n_model = 0;

    repeat (4) applyStimulus(1'b1, 1'b0, 4'b0001, "on_ch0");
    repeat (2) applyStimulus(1'b1, 1'b0, 4'b0000, "all_off");
    repeat (3) applyStimulus(1'b1, 1'b0, 4'b0001, "pre_reset");

    // Asynchronous reset in the middle of a cycle while ch0 is lit.
    @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    checkOutput("async_rst_led", int'(led_o), 0);
    checkOutput("async_rst_cycle", int'(cycle_o), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    n_model = 0;

    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 1'b0, 4'b0110, "post_reset");
      checkTimebase("post_reset");
    end

    // Breath on both channels for one full phase period.
    clearWindows();
    applyStimulus(1'b1, 1'b1, 4'b1010, "restart_breath");
    win_en = 1;
    for (int k = 0; k < 256; k++) applyStimulus(1'b1, 1'b0, 4'b1010, "breath");
    win_en = 0;
    applyStimulus(1'b1, 1'b0, 4'b1010, "breath_tail");
    checkOutput("breath_ch0_pos3_hi", hi0[3], 6);
    checkOutput("breath_ch0_pos12_hi", hi0[12], 6);
    checkOutput("breath_ch0_pos0_hi", hi0[0], 0);
    checkOutput("breath_ch1_pos0_hi", hi1[0], 14);
    checkOutput("breath_cycle_pulses", cyc_acc, 1);

    // Blink on both channels: ch1 is the inverse of ch0.
    clearWindows();
    applyStimulus(1'b1, 1'b1, 4'b1111, "restart_blink");
    win_en = 1;
    for (int k = 0; k < 256; k++) applyStimulus(1'b1, 1'b0, 4'b1111, "blink");
    win_en = 0;
    applyStimulus(1'b1, 1'b0, 4'b1111, "blink_tail");
    checkOutput("blink_ch0_pos0_hi", hi0[0], 0);
    checkOutput("blink_ch0_pos7_hi", hi0[7], 0);
    checkOutput("blink_ch0_pos8_hi", hi0[8], 16);
    checkOutput("blink_ch0_pos15_hi", hi0[15], 16);
    checkOutput("blink_ch1_pos0_hi", hi1[0], 16);
    checkOutput("blink_ch1_pos8_hi", hi1[8], 0);

    // Restart mid-period at pos 5.
    while (n_model != 85) applyStimulus(1'b1, 1'b0, 4'b1010, "to_pos5");
    applyStimulus(1'b1, 1'b1, 4'b1010, "restart_pos5");
    applyStimulus(1'b1, 1'b0, 4'b1010, "after_restart");
    checkTimebase("after_restart");

    // Restart coinciding with the pos wrap must suppress cycle_o.
    while (n_model != 255) applyStimulus(1'b1, 1'b0, 4'b1010, "to_wrap");
    applyStimulus(1'b1, 1'b1, 4'b1010, "restart_wrap");
    clearWindows();
    win_en = 1;
    for (int k = 0; k < 20; k++) applyStimulus(1'b1, 1'b0, 4'b1010, "post_wrap");
    win_en = 0;
    applyStimulus(1'b1, 1'b0, 4'b1010, "post_wrap_tail");
    checkOutput("restart_wrap_no_cycle", cyc_acc, 0);

    // Enable low holds everything cleared even with channels forced on.
    applyStimulus(1'b0, 1'b0, 4'b0101, "en_low");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 4'b0101, "en_low");
      checkTimebase("en_low");
    end
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, 1'b0, 4'b0101, "en_resume");
      checkTimebase("en_resume");
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/breath_led_multi.md
Name: breath_led_multi

Overview:
- Multi-channel breathing-LED driver. It is the parametrised successor of the team's single-channel fixed 2 us/2 ms/2 s breath block.
- One shared timebase (prescaler, PWM counter, triangle phase accumulator) drives CH_NUM PWM outputs.
- Each channel has an evenly spaced phase offset and a per-channel mode: off, on, breath or blink.
- Sits between the board clock/reset and the LED pins. Mode bits come from a control register or straps.

Parameters:
- CH_NUM, 4: number of LED channels (1..16).
- CLK_DIV, 50: clk cycles per PWM tick (>=1). 50 at 25 MHz gives 2 us.
- PWM_BITS, 10: PWM resolution. A frame is 2^PWM_BITS ticks.
- HOLD_FRAMES, 1: frames per phase-accumulator step (>=1).

Ports:
- clk  input  1  system clock (25 MHz nominal)
- rst_n  input  1  reset
- en  input  1  block enable; low holds the block cleared
- restart  input  1  synchronous one-cycle pulse that clears the timebase
- mode  input  2*CH_NUM  channel i uses mode[2i+1:2i]: 00 off, 01 on, 10 breath, 11 blink
- led_o  output  CH_NUM  registered LED drive, active high
- cycle_o  output  1  one-cycle pulse each time the phase accumulator wraps

Interface rule: reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Reset (rst_n=0): prescaler, pwm_cnt, frame counter, pos, led_o and cycle_o are all 0.
- Prescaler: counts 0..CLK_DIV-1 and wraps. tick = (prescaler==CLK_DIV-1).
- pwm_cnt: PWM_BITS wide, increments on tick and wraps from 2^PWM_BITS-1 to 0.
- frame_end = tick && pwm_cnt==all-ones.
- Frame counter: counts 0..HOLD_FRAMES-1 on frame_end.
- step = frame_end && frame counter==HOLD_FRAMES-1.
- pos: PWM_BITS+1 bits. On step, pos <= pos+1 (modulo 2^(PWM_BITS+1)).
- cycle_o: 1 for exactly the clock after a step that wraps pos from all-ones to 0. Otherwise 0.
- Channel phase: p_i = pos + OFF_i, modulo 2^(PWM_BITS+1).
  - OFF_i = (i * 2^(PWM_BITS+1)) / CH_NUM, integer division, elaboration-time constant.
- Triangle: t_i = p_i[PWM_BITS] ? ~p_i[PWM_BITS-1:0] : p_i[PWM_BITS-1:0].
  - Result ramps 0 to max, then max to 0.
- duty_i = t_i (linear; see Optional Feature).
- led_o[i] next value, set by mode:
  - 00: 0
  - 01: 1
  - 10: (duty_i > pwm_cnt)
  - 11: p_i[PWM_BITS], i.e. on for the second half of the period, off for the first
- Latency: led_o is registered from the current-cycle pwm_cnt/pos/mode, giving 1 clk latency. A mode change is visible on the next clk.
- Duty boundaries:
  - duty 0 gives led off for the whole frame.
  - duty 2^PWM_BITS-1 gives led on for all but the last tick of the frame.
- en=0: all counters and pos are forced to 0 synchronously, led_o<=0, cycle_o<=0. Operation resumes from 0 the cycle after en returns to 1.
- restart=1 (with en=1): prescaler, pwm_cnt, frame counter and pos are cleared to 0.
  - cycle_o is not pulsed.
  - led_o still updates from the pre-clear state that cycle.
  - restart takes priority over a coincident step or wrap.
- Reset mid-operation: asynchronous return to the reset values, with no glitch pulse on cycle_o.
- Arithmetic is unsigned. The offset add truncates to PWM_BITS+1 bits.

Optional Feature:
- Macro BREATH_GAMMA_EN.
- Defined: duty_i = (t_i * t_i) >> PWM_BITS.
  - The product is 2*PWM_BITS bits wide; the upper PWM_BITS bits are used.
  - This is a square-law perceptual curve, one pipeline-free combinational multiply per channel.
  - Example: PWM_BITS=3, t=7 gives duty 6; t=3 gives duty 1.
- Undefined: duty_i = t_i (linear). No multiplier is synthesised.
- Blink, on and off modes are unaffected either way.

Test Plan:
Bench parameters: CH_NUM=2, CLK_DIV=2, PWM_BITS=3, HOLD_FRAMES=1. A frame is 16 clk; a pos period is 16 frames; OFF_1=8.
1. Assert rst_n=0 mid-run -> led_o=2'b00 and cycle_o=0 immediately; after release, pwm_cnt advances every 2 clk.
2. en=1, mode=4'b0001 (ch0 on, ch1 off) -> led_o=2'b01 from the 1st clk after the change; mode=4'b0000 -> 2'b00 the next clk.
3. Breath on ch0, linear:
   - Frame with pos=3 -> led_o[0] high 6 of 16 clk (pwm_cnt 0..2).
   - Frame with pos=12 -> duty=3, same 6 of 16.
   - Frame with pos=0 -> low all 16.
4. Breath on ch1, frame with pos=0 -> p_1=8, duty=7 -> high 14 of 16 clk. cycle_o pulses exactly once every 256 clk.
5. Blink on both -> led_o[0] low in frames with pos 0..7 and high in 8..15; led_o[1] is the exact inverse.
6. restart pulse during pos=5 -> the next frame has pos=0 and no cycle_o pulse. en=0 -> led_o=0 the next clk; counters read 0 until en=1.
